// File: rtl/retire_mon_pkg.sv
// retire_mon_pkg
// Shared types and constants for the retire monitor.
//   mon_state_t    : run-control state (RUN, HALTED, TIMEOUT)
//   INSTR_ECALL    : RV32I ECALL encoding
//   INSTR_EBREAK   : RV32I EBREAK encoding
//   trace_entry_t  : one trace record, sized for XLEN = 32
//   is_halt_instr  : true for an instruction word that ends the program
package retire_mon_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTED  = 2'd1,
        TIMEOUT = 2'd2
    } mon_state_t;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
    } trace_entry_t;

    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
    endfunction

endpackage

// File: rtl/retire_trace_buf.sv
// retire_trace_buf
// DEPTH-entry circular trace buffer with a saturating entry count and a
// registered, read-before-write indexed read port.
// Ports:
//   clk_i, reset_i        : clock, synchronous active-high reset
//   wr_en_i               : record one entry this cycle
//   wr_pc_i/instr_i/result_i : entry fields
//   rd_req_i, rd_idx_i    : read request, index 0 = most recent entry
//   rd_valid_o            : one-cycle response strobe
//   rd_hit_o              : rd_idx_i was below the entry count at request time
//   rd_pc_o/instr_o/result_o : read data (zero on a miss, held when idle)
//   entries_o             : valid entry count, saturates at DEPTH
// Storage is not cleared by reset; only the pointer and count are.
module retire_trace_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [XLEN-1:0]  wr_pc_i,
    input  logic [31:0]      wr_instr_i,
    input  logic [XLEN-1:0]  wr_result_i,
    input  logic             rd_req_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic             rd_hit_o,
    output logic [XLEN-1:0]  rd_pc_o,
    output logic [31:0]      rd_instr_o,
    output logic [XLEN-1:0]  rd_result_o,
    output logic [IDX_W:0]   entries_o
);

    localparam logic [IDX_W:0] FULL_C = (IDX_W+1)'(DEPTH);

    logic [XLEN-1:0] pc_mem     [DEPTH];
    logic [31:0]     instr_mem  [DEPTH];
    logic [XLEN-1:0] result_mem [DEPTH];

    logic [IDX_W-1:0] wp_q, wp_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0] rd_slot;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_hit_q, rd_hit_d;
    logic [XLEN-1:0]  rd_pc_q, rd_pc_d;
    logic [31:0]      rd_instr_q, rd_instr_d;
    logic [XLEN-1:0]  rd_result_q, rd_result_d;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign rd_slot = wp_q - IDX_W'(1) - rd_idx_i;

    always_comb begin
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        rd_valid_d  = rd_req_i;
        rd_hit_d    = rd_hit_q;
        rd_pc_d     = rd_pc_q;
        rd_instr_d  = rd_instr_q;
        rd_result_d = rd_result_q;
        if (wr_en_i) begin
            wp_d = wp_q + IDX_W'(1);
            if (cnt_q != FULL_C) begin
                cnt_d = cnt_q + (IDX_W+1)'(1);
            end
        end
        if (rd_req_i) begin
            rd_hit_d    = ({1'b0, rd_idx_i} < cnt_q);
            rd_pc_d     = rd_hit_d ? pc_mem[rd_slot]     : '0;
            rd_instr_d  = rd_hit_d ? instr_mem[rd_slot]  : '0;
            rd_result_d = rd_hit_d ? result_mem[rd_slot] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wp_q        <= '0;
            cnt_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_hit_q    <= 1'b0;
            rd_pc_q     <= '0;
            rd_instr_q  <= '0;
            rd_result_q <= '0;
        end else begin
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_hit_q    <= rd_hit_d;
            rd_pc_q     <= rd_pc_d;
            rd_instr_q  <= rd_instr_d;
            rd_result_q <= rd_result_d;
        end
    end

    // Writer is gated by the parent (never active during reset).
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            pc_mem[wp_q]     <= wr_pc_i;
            instr_mem[wp_q]  <= wr_instr_i;
            result_mem[wp_q] <= wr_result_i;
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_hit_o    = rd_hit_q;
    assign rd_pc_o     = rd_pc_q;
    assign rd_instr_o  = rd_instr_q;
    assign rd_result_o = rd_result_q;
    assign entries_o   = cnt_q;

endmodule

// File: rtl/retire_monitor.sv
// retire_monitor
// Run-control and trace monitor at the retire point of an RV32I datapath.
// Records the last DEPTH retirements, counts RUN cycles and retirements,
// halts on ECALL/EBREAK or LOOP_LIMIT consecutive retires at one PC, and
// times out after TIMEOUT_CYCLES RUN cycles. HALTED/TIMEOUT are terminal.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   retire_valid/pc/instr/result : retirement stream
//   rd_req, rd_idx        : trace read (0 = most recent), one-cycle latency
//   rd_valid, rd_hit, rd_pc, rd_instr, rd_result : trace read response
//   entries, cycle_count, retire_count : status
//   halted, timed_out     : registered state decodes (expose the FSM state)
// Optional macro RETIRE_MON_DISPLAY_EN: prints a one-line report in
// simulation on the edge entering HALTED or TIMEOUT.
module retire_monitor
    import retire_mon_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 16,
    parameter int LOOP_LIMIT     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32,
    localparam int IDX_W         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [31:0]      retire_instr,
    input  logic [XLEN-1:0]  retire_result,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_hit,
    output logic [XLEN-1:0]  rd_pc,
    output logic [31:0]      rd_instr,
    output logic [XLEN-1:0]  rd_result,
    output logic [IDX_W:0]   entries,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic             halted,
    output logic             timed_out
);

    localparam logic [7:0]       LOOP_LIM_C = 8'(LOOP_LIMIT);
    localparam logic [CNT_W-1:0] WDOG_C     = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [7:0]       loop_q, loop_d;
    logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
    logic             halted_q, timed_out_q;
    logic             trace_wr;
    logic             halt_now;

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        loop_d    = loop_q;
        prev_pc_d = prev_pc_q;
        trace_wr  = 1'b0;
        halt_now  = 1'b0;
        case (state_q)
            RUN: begin
                cycle_d = cycle_q + CNT_W'(1);
                if (retire_valid) begin
                    trace_wr  = !reset;
                    retire_d  = retire_q + CNT_W'(1);
                    prev_pc_d = retire_pc;
                    // loop_q == 0 only before the first retire after reset,
                    // so it doubles as "no previous PC yet".
                    if (loop_q != 8'd0 && retire_pc == prev_pc_q) begin
                        loop_d = loop_q + 8'd1;
                    end else begin
                        loop_d = 8'd1;
                    end
                    halt_now = is_halt_instr(retire_instr) || (loop_d == LOOP_LIM_C);
                end
                // A halt on the watchdog edge takes priority.
                if (halt_now) begin
                    state_d = HALTED;
                end else if (cycle_q == WDOG_C) begin
                    state_d = TIMEOUT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cycle_q     <= '0;
            retire_q    <= '0;
            loop_q      <= '0;
            prev_pc_q   <= '0;
            halted_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            retire_q    <= retire_d;
            loop_q      <= loop_d;
            prev_pc_q   <= prev_pc_d;
            halted_q    <= (state_d == HALTED);
            timed_out_q <= (state_d == TIMEOUT);
        end
    end

    retire_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_trace (
        .clk_i       (clk),
        .reset_i     (reset),
        .wr_en_i     (trace_wr),
        .wr_pc_i     (retire_pc),
        .wr_instr_i  (retire_instr),
        .wr_result_i (retire_result),
        .rd_req_i    (rd_req),
        .rd_idx_i    (rd_idx),
        .rd_valid_o  (rd_valid),
        .rd_hit_o    (rd_hit),
        .rd_pc_o     (rd_pc),
        .rd_instr_o  (rd_instr),
        .rd_result_o (rd_result),
        .entries_o   (entries)
    );

    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign halted       = halted_q;
    assign timed_out    = timed_out_q;

`ifdef RETIRE_MON_DISPLAY_EN
    trace_entry_t last_q;
    trace_entry_t last_now;

    // The halting retire is itself the last one reported.
    assign last_now = trace_wr ? {32'(retire_pc), retire_instr, 32'(retire_result)} : last_q;

    always_ff @(posedge clk) begin
        if (trace_wr) begin
            last_q <= last_now;
        end
        if (!reset && state_q == RUN && state_d != RUN) begin
            $display("%0t retire_monitor %s pc=%h instr=%h result=%h cycles=%0d retires=%0d",
                     $time, state_d.name(), last_now.pc, last_now.instr, last_now.result,
                     cycle_d, retire_d);
        end
    end
`else
`endif

endmodule
